// File: rtl/mem_bus_arbiter_pkg.sv
// Shared processor package for the memory bus arbiter.
// Holds the bus geometry, the memory request tag encodings, the number of
// beats per cache line, the arbiter FSM state enum and a small address helper.
package mem_bus_arbiter_pkg;

    localparam int BUS_DATA_WIDTH = 64;
    localparam int BUS_TAG_WIDTH  = 13;
    localparam int CELLS_NEEDED   = 8;

    localparam logic [BUS_TAG_WIDTH-1:0] MEM_READ  = 13'h0001;
    localparam logic [BUS_TAG_WIDTH-1:0] MEM_WRITE = 13'h0002;

    // Beat counter value of the final beat of a line transfer.
    localparam logic [2:0] LAST_BEAT = 3'(CELLS_NEEDED - 1);

    // Byte-offset bits within a 64-byte line.
    localparam logic [BUS_DATA_WIDTH-1:0] LINE_MASK = 64'h0000_0000_0000_003F;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        RESP  = 3'd3,
        DONE  = 3'd4
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Align an address to the start of its cache line.
    function automatic logic [BUS_DATA_WIDTH-1:0] line_addr(input logic [BUS_DATA_WIDTH-1:0] a);
        return a & ~LINE_MASK;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter between an instruction cache (fills only) and a data
// cache (fills and writebacks). One requester owns the bus per transaction;
// contended arbitration alternates, with d winning the first one after reset.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   i_req/i_addr          icache fill request, address held until i_done
//   d_req/d_write/d_addr  dcache request (write=1 -> writeback), held until d_done
//   d_wdata / d_wnext     writeback beat and its per-beat consumption pulse
//   i_grant/d_grant       bus ownership, ADDR through DONE
//   *_rdata/*_rvalid      fill beats routed to the owner
//   i_done/d_done         one-cycle end-of-transaction pulse
//   bus_req*              memory request channel (cyc/data/tag, ack in)
//   bus_resp*             memory response channel (cyc/data/tag in, ack out)
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_req,
    input  logic [BUS_DATA_WIDTH-1:0]  i_addr,
    input  logic                       d_req,
    input  logic                       d_write,
    input  logic [BUS_DATA_WIDTH-1:0]  d_addr,
    input  logic [BUS_DATA_WIDTH-1:0]  d_wdata,
    output logic                       i_grant,
    output logic                       d_grant,
    output logic [BUS_DATA_WIDTH-1:0]  i_rdata,
    output logic                       i_rvalid,
    output logic [BUS_DATA_WIDTH-1:0]  d_rdata,
    output logic                       d_rvalid,
    output logic                       i_done,
    output logic                       d_done,
    output logic                       d_wnext,
    output logic                       bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]  bus_req,
    output logic [BUS_TAG_WIDTH-1:0]   bus_reqtag,
    input  logic                       bus_reqack,
    input  logic                       bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]  bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]   bus_resptag,
    output logic                       bus_respack
);

    arb_state_t                 state_r, state_s;
    owner_t                     owner_r, owner_s;
    owner_t                     last_r, last_s;
    logic                       write_r, write_s;
    logic                       contended_r, contended_s;
    logic [BUS_DATA_WIDTH-1:0]  addr_r, addr_s;
    logic [2:0]                 cnt_r, cnt_s;

    // State register: synchronous active-low reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            owner_r     <= OWN_I;
            last_r      <= OWN_I;
            write_r     <= 1'b0;
            contended_r <= 1'b0;
            addr_r      <= 64'h0;
            cnt_r       <= 3'd0;
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            last_r      <= last_s;
            write_r     <= write_s;
            contended_r <= contended_s;
            addr_r      <= addr_s;
            cnt_r       <= cnt_s;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        last_s      = last_r;
        write_s     = write_r;
        contended_s = contended_r;
        addr_s      = addr_r;
        cnt_s       = cnt_r;

        i_grant     = 1'b0;
        d_grant     = 1'b0;
        i_rdata     = 64'h0;
        i_rvalid    = 1'b0;
        d_rdata     = 64'h0;
        d_rvalid    = 1'b0;
        i_done      = 1'b0;
        d_done      = 1'b0;
        d_wnext     = 1'b0;
        bus_reqcyc  = 1'b0;
        bus_req     = 64'h0;
        bus_reqtag  = 13'h0;
        bus_respack = 1'b0;

        if (state_r != IDLE) begin
            i_grant = (owner_r == OWN_I);
            d_grant = (owner_r == OWN_D);
        end else begin
            i_grant = 1'b0;
            d_grant = 1'b0;
        end

        case (state_r)
            IDLE: begin
                // d wins unless i is also pending and d won the last contest.
                if (d_req && (!i_req || (last_r == OWN_I))) begin
                    state_s     = ADDR;
                    owner_s     = OWN_D;
                    write_s     = d_write;
                    addr_s      = line_addr(d_addr);
                    contended_s = i_req;
                    cnt_s       = 3'd0;
                end else if (i_req) begin
                    state_s     = ADDR;
                    owner_s     = OWN_I;
                    write_s     = 1'b0;
                    addr_s      = line_addr(i_addr);
                    contended_s = d_req;
                    cnt_s       = 3'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR: begin
                bus_reqcyc = 1'b1;
                bus_req    = addr_r;
                bus_reqtag = write_r ? MEM_WRITE : MEM_READ;
                if (bus_reqack) begin
                    state_s = write_r ? WDATA : RESP;
                end else begin
                    state_s = ADDR;
                end
            end
            WDATA: begin
                bus_reqcyc = 1'b1;
                bus_req    = d_wdata;
                bus_reqtag = MEM_WRITE;
                if (bus_reqack) begin
                    d_wnext = 1'b1;
                    cnt_s   = cnt_r + 3'd1;
                    state_s = (cnt_r == LAST_BEAT) ? DONE : WDATA;
                end else begin
                    state_s = WDATA;
                end
            end
            RESP: begin
                if (bus_respcyc) begin
                    // Every beat is consumed; only read-tagged beats count.
                    bus_respack = 1'b1;
                    if (bus_resptag == MEM_READ) begin
                        if (owner_r == OWN_D) begin
                            d_rdata  = bus_resp;
                            d_rvalid = 1'b1;
                        end else begin
                            i_rdata  = bus_resp;
                            i_rvalid = 1'b1;
                        end
                        cnt_s   = cnt_r + 3'd1;
                        state_s = (cnt_r == LAST_BEAT) ? DONE : RESP;
                    end else begin
                        state_s = RESP;
                    end
                end else begin
                    state_s = RESP;
                end
            end
            DONE: begin
                i_done  = (owner_r == OWN_I);
                d_done  = (owner_r == OWN_D);
                // Only a contested grant moves the fairness pointer, so an
                // uncontested grant never costs the other port its turn.
                if (contended_r) begin
                    last_s = owner_r;
                end else begin
                    last_s = last_r;
                end
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fill beats are pushed to a scoreboard
// as they are driven and popped by a monitor when the DUT routes them.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [63:0] i_addr = 64'h0;
    logic        d_req = 1'b0;
    logic        d_write = 1'b0;
    logic [63:0] d_addr = 64'h0;
    logic [63:0] d_wdata = 64'h0;
    logic        i_grant, d_grant, i_rvalid, d_rvalid, i_done, d_done, d_wnext;
    logic [63:0] i_rdata, d_rdata, bus_req;
    logic        bus_reqcyc, bus_respack;
    logic [12:0] bus_reqtag;
    logic        bus_reqack = 1'b0;
    logic        bus_respcyc = 1'b0;
    logic [63:0] bus_resp = 64'h0;
    logic [12:0] bus_resptag = 13'h0;

    typedef struct {
        logic        own_d;
        logic [63:0] data;
    } beat_t;

    beat_t sb[$];
    int tests = 0;
    int fails = 0;
    int i_done_cnt = 0;
    int d_done_cnt = 0;
    int wnext_cnt = 0;

    mem_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .i_grant(i_grant), .d_grant(d_grant),
        .i_rdata(i_rdata), .i_rvalid(i_rvalid),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .i_done(i_done), .d_done(d_done), .d_wnext(d_wnext),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .bus_respack(bus_respack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check(tag, {55'h0, i_grant, d_grant, i_rvalid, d_rvalid, i_done, d_done,
                    d_wnext, bus_reqcyc, bus_respack}, 64'h0);
    endtask

    // Monitor: routed beats against the scoreboard, exclusive grants, pulse counts.
    always @(negedge clk) begin
        if (i_rvalid || d_rvalid) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", {62'h0, d_rvalid, i_rvalid}, 64'h0);
            end else begin
                beat_t b;
                b = sb.pop_front();
                check("beat_owner", {62'h0, d_rvalid, i_rvalid}, b.own_d ? 64'h2 : 64'h1);
                check("beat_data", b.own_d ? d_rdata : i_rdata, b.data);
            end
        end
        if (i_grant && d_grant) check("both_granted", 64'h1, 64'h0);
        if (i_done) i_done_cnt++;
        if (d_done) d_done_cnt++;
        if (d_wnext) wnext_cnt++;
    end

    // Runs a fill from its ADDR cycle to its DONE cycle, then drops the request.
    task automatic serve_fill(input logic own_d, input logic [63:0] addr,
                              input logic [63:0] base, input int ack_delay, input int bad_at);
        logic [63:0] exp_addr;
        exp_addr = {addr[63:6], 6'b000000};
        for (int w = 0; w < ack_delay; w++) begin
            bus_reqack = 1'b0;
            #2;
            check("addr_wait_reqcyc", bus_reqcyc, 64'h1);
            next();
        end
        bus_reqack = 1'b1;
        #2;
        check("grant_own", own_d ? d_grant : i_grant, 64'h1);
        check("grant_other", own_d ? i_grant : d_grant, 64'h0);
        check("addr_reqcyc", bus_reqcyc, 64'h1);
        check("addr_req", bus_req, exp_addr);
        check("addr_tag", bus_reqtag, 64'(MEM_READ));
        next();
        bus_reqack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == bad_at) begin
                bus_respcyc = 1'b1;
                bus_resp    = 64'hBAD0_BAD0;
                bus_resptag = MEM_WRITE;
                #2;
                check("bad_tag_ack", bus_respack, 64'h1);
                next();
            end
            bus_respcyc = 1'b1;
            bus_resp    = base + 64'(k);
            bus_resptag = MEM_READ;
            sb.push_back('{own_d, base + 64'(k)});
            #2;
            check("resp_ack", bus_respack, 64'h1);
            check("resp_reqcyc_low", bus_reqcyc, 64'h0);
            check("resp_other_grant", own_d ? i_grant : d_grant, 64'h0);
            next();
        end
        bus_respcyc = 1'b0;
        bus_resp    = 64'h0;
        bus_resptag = 13'h0;
        #2;
        check("done_own", own_d ? d_done : i_done, 64'h1);
        check("done_other", own_d ? i_done : d_done, 64'h0);
        check("done_grant", own_d ? d_grant : i_grant, 64'h1);
        if (own_d) d_req = 1'b0; else i_req = 1'b0;
        next();
    endtask

    initial begin
        int icnt;
        int dcnt;
        // Reset
        next();
        next();
        #2;
        check_quiet("reset_outputs");
        check("reset_bus_req", bus_req, 64'h0);
        reset = 1'b1;
        next();
        #2;
        check_quiet("idle_no_req");

        // Lone i fill, ack after two cycles, beats 0..7
        next();
        i_req  = 1'b1;
        i_addr = 64'h1047;
        #2;
        check("idle_grant_low", i_grant, 64'h0);
        next();
        serve_fill(1'b0, 64'h1047, 64'h0, 2, -1);
        #2;
        check("t1_idle_after", i_grant, 64'h0);
        check("t1_done_count", 64'(i_done_cnt), 64'h1);
        check("t1_sb_empty", 64'(sb.size()), 64'h0);

        // Simultaneous pairs after reset: d first, then i; second pair i first
        reset = 1'b0;
        next();
        reset = 1'b1;
        i_req = 1'b1; i_addr = 64'h3000;
        d_req = 1'b1; d_write = 1'b0; d_addr = 64'h4010;
        next();
        serve_fill(1'b1, 64'h4010, 64'h100, 0, -1);
        #2;
        check("pair1_i_waits", i_grant, 64'h0);
        next();
        serve_fill(1'b0, 64'h3000, 64'h200, 0, -1);
        i_req = 1'b1; i_addr = 64'h5040;
        d_req = 1'b1; d_addr = 64'h6080;
        next();
        serve_fill(1'b0, 64'h5040, 64'h300, 0, -1);
        next();
        serve_fill(1'b1, 64'h6080, 64'h400, 0, -1);
        check("pair_done_counts", {32'(i_done_cnt), 32'(d_done_cnt)}, {32'd3, 32'd2});

        // d writeback, data A0..A7, one stalled beat, req dropped mid-way
        d_req = 1'b1; d_write = 1'b1; d_addr = 64'h2000; d_wdata = 64'hA0;
        next();
        bus_reqack = 1'b1;
        #2;
        check("wb_addr", bus_req, 64'h2000);
        check("wb_addr_tag", bus_reqtag, 64'(MEM_WRITE));
        check("wb_addr_wnext", d_wnext, 64'h0);
        next();
        for (int k = 0; k < 8; k++) begin
            d_wdata = 64'hA0 + 64'(k);
            if (k == 2) d_req = 1'b0;
            if (k == 3) begin
                bus_reqack = 1'b0;
                #2;
                check("wb_stall_wnext", d_wnext, 64'h0);
                next();
            end
            bus_reqack = 1'b1;
            #2;
            check("wb_data", bus_req, 64'hA0 + 64'(k));
            check("wb_tag", bus_reqtag, 64'(MEM_WRITE));
            check("wb_wnext", d_wnext, 64'h1);
            next();
        end
        bus_reqack = 1'b0;
        #2;
        check("wb_done", d_done, 64'h1);
        check("wb_reqcyc_low", bus_reqcyc, 64'h0);
        next();
        check("wb_wnext_count", 64'(wnext_cnt), 64'h8);
        check("wb_done_count", 64'(d_done_cnt), 64'h3);

        // i fill with a foreign-tag beat inserted after two valid beats
        i_req = 1'b1; i_addr = 64'h7FFF;
        next();
        serve_fill(1'b0, 64'h7FFF, 64'h500, 1, 2);
        check("badtag_sb_empty", 64'(sb.size()), 64'h0);

        // Reset after three beats: no done, then a clean restart
        icnt = i_done_cnt;
        dcnt = d_done_cnt;
        i_req = 1'b1; i_addr = 64'h8000;
        next();
        bus_reqack = 1'b1;
        next();
        bus_reqack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus_respcyc = 1'b1; bus_resp = 64'h600 + 64'(k); bus_resptag = MEM_READ;
            sb.push_back('{1'b0, 64'h600 + 64'(k)});
            next();
        end
        bus_respcyc = 1'b0;
        reset = 1'b0;
        next();
        reset = 1'b1;
        #2;
        check_quiet("post_reset_quiet");
        next();
        serve_fill(1'b0, 64'h8000, 64'h700, 0, -1);
        check("abort_no_extra_done", {32'(i_done_cnt), 32'(d_done_cnt)}, {32'(icnt + 1), 32'(dcnt)});
        check("final_sb_empty", 64'(sb.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
